// File: rtl/hardfloat_vector_source_if.sv
// Byte-stream link between the vector source and its consumer.
//   byte_valid : source -> sink, byte_data holds a character
//   byte_ready : sink -> source, byte accepted this cycle
//   byte_data  : source -> sink, ASCII character
interface hardfloat_vector_source_if;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/hardfloat_vector_source.sv
// Pseudo-random floating-point test-vector generator. Each vector is NUM_OPS
// operands of W = EXP_WIDTH + SIG_WIDTH bits, printed as lowercase hex,
// separated by spaces and terminated by a newline, on a valid/ready byte link.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse, seeds the generator and begins a run
//   bus        : byte stream (master side: byte_valid, byte_data out; byte_ready in)
//   busy       : run in progress
//   done       : COUNT vectors emitted (held until the next start)
//   vec_count  : completed vectors in the current run
//
// Optional feature macro: HARDFLOAT_SPECIAL_VEC_EN
//   When defined, operand 0 of every vector with (vec_count mod 8) == 7 is
//   replaced by +0 / -0 / +inf / default qNaN chosen by vec_count[4:3].
//   The random sequence is unaffected.
module hardfloat_vector_source #(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned SIG_WIDTH = 24,
  parameter int unsigned NUM_OPS   = 2,
  parameter logic [31:0] SEED      = 32'h1,
  parameter logic [31:0] COUNT     = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  hardfloat_vector_source_if.master  bus,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                vec_count
);

  localparam int unsigned W        = EXP_WIDTH + SIG_WIDTH;
  localparam int unsigned NIBS     = W / 4;
  localparam int unsigned NIB_W    = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int unsigned STEPS    = (W + 31) / 32;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [1:0]  LAST_OP  = 2'(NUM_OPS - 1);

  // Elaboration-time parameter sanity check
  if ((W % 4) != 0 || W > 64 || NUM_OPS < 1 || NUM_OPS > 3) begin : g_param_check
    $error("hardfloat_vector_source: unsupported EXP_WIDTH/SIG_WIDTH/NUM_OPS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIGIT,
    S_SEP,
    S_NL,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [W-1:0]      operand_q, operand_d;
  logic [NIB_W-1:0]  nib_q, nib_d;
  logic [1:0]        op_idx_q, op_idx_d;
  logic [31:0]       vec_count_q, vec_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;

  logic [31:0]       step1, step2, lfsr_adv;
  logic [63:0]       cat;
  logic [W-1:0]      operand_c;
  logic [NIB_W-1:0]  nib_dec;
  logic              xfer;
  logic [31:0]       vec_count_inc;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

`ifdef HARDFLOAT_SPECIAL_VEC_EN
  localparam logic [W-1:0] SIGN_BIT = W'(1) << (W - 1);
  localparam logic [W-1:0] EXP_ONES = ((W'(1) << EXP_WIDTH) - W'(1)) << (SIG_WIDTH - 1);
  localparam logic [W-1:0] QNAN_BIT = W'(1) << (SIG_WIDTH - 2);
`endif

  // Next operand: ceil(W/32) generator steps, first result most significant
  always_comb begin
    step1 = xs_step(lfsr_q);
    step2 = xs_step(step1);
    if (STEPS == 1) begin
      cat      = {32'h0, step1};
      lfsr_adv = step1;
    end else begin
      cat      = {step1, step2};
      lfsr_adv = step2;
    end
    operand_c = cat[W-1:0];
`ifdef HARDFLOAT_SPECIAL_VEC_EN
    // Steps above are still consumed, so the random stream is unchanged
    if (op_idx_q == 2'd0 && vec_count_q[2:0] == 3'b111) begin
      case (vec_count_q[4:3])
        2'd0:    operand_c = '0;
        2'd1:    operand_c = SIGN_BIT;
        2'd2:    operand_c = EXP_ONES;
        default: operand_c = EXP_ONES | QNAN_BIT;
      endcase
    end
`endif
  end

  assign xfer          = byte_valid_q & bus.byte_ready;
  assign nib_dec       = nib_q - NIB_W'(1);
  assign vec_count_inc = vec_count_q + 32'd1;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED_EFF;
      operand_q    <= '0;
      nib_q        <= '0;
      op_idx_q     <= 2'd0;
      vec_count_q  <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      operand_q    <= operand_d;
      nib_q        <= nib_d;
      op_idx_q     <= op_idx_d;
      vec_count_q  <= vec_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    operand_d    = operand_q;
    nib_d        = nib_q;
    op_idx_d     = op_idx_q;
    vec_count_d  = vec_count_q;
    busy_d       = busy_q;
    done_d       = done_q;
    byte_valid_d = byte_valid_q;
    byte_data_d  = byte_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_d      = SEED_EFF;
          vec_count_d = 32'd0;
          op_idx_d    = 2'd0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        // Register the first digit directly so it is valid on entry to DIGIT
        operand_d    = operand_c;
        lfsr_d       = lfsr_adv;
        nib_d        = NIB_W'(NIBS - 1);
        byte_data_d  = hex_char(operand_c[W-1 -: 4]);
        byte_valid_d = 1'b1;
        state_d      = S_DIGIT;
      end
      S_DIGIT: begin
        if (xfer) begin
          if (nib_q != '0) begin
            nib_d       = nib_dec;
            byte_data_d = hex_char(4'(operand_q >> {nib_dec, 2'b00}));
          end else if (op_idx_q != LAST_OP) begin
            byte_data_d = 8'h20;
            state_d     = S_SEP;
          end else begin
            byte_data_d = 8'h0a;
            state_d     = S_NL;
          end
        end
      end
      S_SEP: begin
        if (xfer) begin
          byte_valid_d = 1'b0;
          op_idx_d     = op_idx_q + 2'd1;
          state_d      = S_LOAD;
        end
      end
      S_NL: begin
        if (xfer) begin
          byte_valid_d = 1'b0;
          op_idx_d     = 2'd0;
          vec_count_d  = vec_count_inc;
          if (COUNT != 32'h0 && vec_count_inc == COUNT) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign vec_count      = vec_count_q;

endmodule

// File: doc/hardfloat_vector_source.md
Name: hardfloat_vector_source

Overview:
- Hardware test-vector generator: the writer at the other end of the stdin text stream that the hardfloat test harness consumes.
- Produces pseudo-random floating-point operand vectors and serialises each one as ASCII text: lowercase hex operands separated by spaces, each vector ending in a newline.
- Output is a valid/ready byte stream, so it can feed a harness-side parser or a UART/host bridge in FPGA bring-up of the hardfloat units.

Parameters:
- EXP_WIDTH, 8, exponent width of the operand format.
- SIG_WIDTH, 24, significand width including the hidden bit. Operand width W = EXP_WIDTH + SIG_WIDTH. W must be a multiple of 4 and no greater than 64.
- NUM_OPS, 2, operands per vector, range 1..3.
- SEED, 32'h1, xorshift32 seed. 0 is replaced by 1.
- COUNT, 0, vectors per run. 0 means unbounded.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: seed the generator and begin a run
- byte_valid  output  1  byte_data holds a valid character
- byte_ready  input  1  sink accepts byte_data this cycle
- byte_data  output  8  ASCII character
- busy  output  1  run in progress
- done  output  1  COUNT vectors emitted; held
- vec_count  output  32  completed vectors in the current run

Behaviour:
- Reset (synchronous, active-high): byte_valid=0, byte_data=0, busy=0, done=0, vec_count=0, state IDLE. Reset mid-vector abandons the partial line; no further bytes are emitted.
- States: IDLE, LOAD, DIGIT, SEP, NL, DONE.
- IDLE/DONE + start: lfsr<=SEED (0 becomes 1), vec_count<=0, done<=0, busy<=1, go to LOAD. start in any other state is ignored.
- Generator step: xorshift32, x^=x<<13; x^=x>>17; x^=x<<5, all 32-bit truncated.
- LOAD (exactly 1 cycle, byte_valid=0):
  - Apply ceil(W/32) steps combinationally.
  - Operand = concatenation of the step results, first result most significant, truncated to the low W bits.
  - Then DIGIT with nibble index W/4-1.
- DIGIT: emit the hex digit of the current nibble ('0'-'9', 'a'-'f'), MSB nibble first.
- Handshake:
  - A byte transfers on byte_valid & byte_ready.
  - Once byte_valid is asserted, byte_data is held stable and byte_valid stays high until the transfer.
  - The next byte of the same operand is presented in the cycle after the transfer, with no bubble.
  - Outputs are registered; there is no combinational byte_ready-to-byte_valid path.
- After the last digit transfers: if more operands remain, go to SEP (0x20), then LOAD; otherwise go to NL (0x0A).
- Each LOAD inserts exactly one byte_valid=0 cycle before every operand.
- On NL transfer: vec_count increments.
  - If COUNT!=0 and the new count equals COUNT: go to DONE, busy<=0, done<=1.
  - Otherwise go to LOAD.
- vec_count wraps at 2^32 when COUNT=0; there is no error.
- Latency: start sampled at edge N gives LOAD at N+1 and the first digit valid after edge N+2.
- start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: HARDFLOAT_SPECIAL_VEC_EN.
- Defined: when (vec_count mod 8)==7, operand 0 of that vector is replaced by a special value selected by vec_count[4:3]:
  - 0 = +0 (all zero)
  - 1 = -0 (sign bit only)
  - 2 = +inf (exponent all ones, fraction 0)
  - 3 = default qNaN (exponent all ones, fraction MSB set)
- The generator steps for the replaced operand are still consumed, so the random sequence is identical with and without the macro.
- Undefined: all operands are random; there is no special-value logic.

Test Plan:
- Defaults, SEED=1, byte_ready=1, pulse start -> byte stream exactly "00042021 04080601\n". busy=1 during the line; vec_count=1 after the 0x0A transfer.
- Hold byte_ready=0 for 5 cycles while the first digit is valid -> byte_valid stays 1 and byte_data stays 0x30 each cycle; the transfer happens the cycle byte_ready rises; the following byte is '0'.
- COUNT=2 -> exactly two lines emitted, then done=1, busy=0, byte_valid=0 held for 100 cycles. A new start -> the first line repeats "00042021 04080601\n" and done clears.
- Assert reset after the 3rd byte of line 1 -> next cycle byte_valid=0, busy=0, vec_count=0. start then reproduces line 1 from its first byte.
- Pulse start while busy -> the stream is unchanged and matches an undisturbed run byte-for-byte.
- With HARDFLOAT_SPECIAL_VEC_EN, defaults:
  - Line index 7 operand 0 = "00000000"; line 15 = "80000000"; line 23 = "7f800000"; line 31 = "7fc00000".
  - Second operands equal those of a macro-less run.
